// File: rtl/bias_pkg.sv
// Shared constants, FSM state type and lane slicing helper for the bias stream buffer.
package bias_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LANES  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Bit offset of a lane inside a packed multi-lane beat.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/bias_bank.sv
// Bias storage: one write port, LANES wrapping combinational read ports, per-entry loaded flags.
module bias_bank
    import bias_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 32,
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [ADDR_W-1:0]       rbase,
    output logic [LANES*DATA_W-1:0] rdata,
    output logic [LANES-1:0]        rloaded
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  loaded;

    // Contents are deliberately left unreset; only the loaded flags are cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loaded <= '0;
        end else if (we) begin
            loaded[waddr] <= 1'b1;
        end
    end

    // DEPTH is a power of two, so ADDR_W-bit addition wraps modulo DEPTH.
    always_comb begin
        rdata   = '0;
        rloaded = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            rdata[lane_lsb(i, DATA_W) +: DATA_W] = mem[rbase + ADDR_W'(i)];
            rloaded[i]                           = loaded[rbase + ADDR_W'(i)];
        end
    end

endmodule

// File: rtl/bias_stream_buffer.sv
// Writable bias store that streams LANES-wide beats to the accumulator over valid/ready.
module bias_stream_buffer
    import bias_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 32,
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [DATA_W-1:0]       ld_data,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_base,
    input  logic [CNT_W-1:0]        req_beats,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_last,
    output logic                    done,
    output logic                    busy,
    output logic                    err,
    input  logic                    err_clr
);

    state_t                    state;
    logic [ADDR_W-1:0]         ptr;
    logic [CNT_W-1:0]          rem;
    logic                      done_zero;

    logic                      idle;
    logic                      ld_fire;
    logic                      req_fire;
    logic                      last_fire;
    logic                      load_beat;
    logic [ADDR_W-1:0]         rd_base;
    logic [CNT_W-1:0]          beat_rem;
    logic [LANES*DATA_W-1:0]   bank_data;
    logic [LANES-1:0]          bank_loaded;
    logic [LANES*DATA_W-1:0]   beat_data;
    logic                      beat_err;

    assign idle      = (state == IDLE);
    assign ld_ready  = idle;
    assign req_ready = idle && !ld_valid;
    assign ld_fire   = ld_valid && ld_ready;
    assign req_fire  = req_valid && req_ready;
    assign last_fire = !idle && out_valid && out_ready && out_last;
    assign done      = done_zero || last_fire;
    assign busy      = !idle;

    // The first beat is fetched straight from req_base on the accepting edge so
    // out_valid rises one cycle after the request; later beats come from ptr.
    assign rd_base   = idle ? req_base  : ptr;
    assign beat_rem  = idle ? req_beats : rem;
    assign load_beat = idle ? (req_fire && req_beats != '0)
                            : ((!out_valid || out_ready) && rem != '0);

    bias_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (ld_fire),
        .waddr   (ld_addr),
        .wdata   (ld_data),
        .rbase   (rd_base),
        .rdata   (bank_data),
        .rloaded (bank_loaded)
    );

    always_comb begin
        beat_data = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (bank_loaded[i]) begin
                beat_data[lane_lsb(i, DATA_W) +: DATA_W] = bank_data[lane_lsb(i, DATA_W) +: DATA_W];
            end
        end
    end

    assign beat_err = ~&bank_loaded;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            rem       <= '0;
            done_zero <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            done_zero <= req_fire && (req_beats == '0);

            if (idle) begin
                if (req_fire && req_beats != '0) begin
                    state <= STREAM;
                end
            end else if (last_fire) begin
                state <= IDLE;
            end

            if (load_beat) begin
                out_valid <= 1'b1;
                out_data  <= beat_data;
                out_last  <= (beat_rem == CNT_W'(1));
                ptr       <= rd_base + ADDR_W'(LANES);
                rem       <= beat_rem - CNT_W'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (load_beat && beat_err) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bias_stream_buffer.sv
// Self-checking bench for bias_stream_buffer: directed vectors plus random traffic against a memory model.
module tb_bias_stream_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        req_valid, req_ready;
    logic [4:0]  req_base;
    logic [7:0]  req_beats;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_last, done, busy, err, err_clr;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] m_mem [32];
    bit         m_vld [32];
    bit         err_exp;

    typedef struct {
        logic [4:0]  base;
        logic [31:0] data;
        logic        err;
    } vec_t;
    vec_t vec [6];

    bias_stream_buffer #(
        .DATA_W (8),
        .DEPTH  (32),
        .LANES  (4),
        .ADDR_W (5),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_base  (req_base),
        .req_beats (req_beats),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_beat(input int base, input int b);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            int a = (base + b * 4 + i) % 32;
            if (m_vld[a]) r[i*8 +: 8] = m_mem[a];
        end
        return r;
    endfunction

    function automatic bit exp_bad(input int base, input int b);
        bit bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!m_vld[(base + b * 4 + i) % 32]) bad = 1'b1;
        end
        return bad;
    endfunction

    // All tasks start and end at posedge + 1.
    task automatic do_load(input int addr, input int data);
        ld_valid = 1'b1;
        ld_addr  = 5'(addr);
        ld_data  = 8'(data);
        @(negedge clk);
        check("ld_ready", ld_ready, 1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        m_mem[addr] = 8'(data);
        m_vld[addr] = 1'b1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
        err_exp = 1'b0;
    endtask

    // mode 0: ready held high, 1: random ready, 2: stall on cycles 1..3
    task automatic run_stream(input int base, input int beats, input int mode);
        logic [31:0] q[$];
        int cyc = 0;
        for (int b = 0; b < beats; b++) begin
            q.push_back(exp_beat(base, b));
            if (exp_bad(base, b)) err_exp = 1'b1;
        end
        req_valid = 1'b1;
        req_base  = 5'(base);
        req_beats = 8'(beats);
        out_ready = 1'b0;
        @(negedge clk);
        check("req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (beats == 0) begin
            @(negedge clk);
            check("zero_done", done, 1);
            check("zero_valid", out_valid, 0);
            check("zero_busy", busy, 0);
            @(posedge clk); #1;
            return;
        end
        while (q.size() > 0 && cyc < beats * 20 + 10) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(cyc >= 1 && cyc <= 3);
            endcase
            @(negedge clk);
            check("out_valid", out_valid, 1);
            check("out_data", out_data, q[0]);
            check("busy", busy, 1);
            if (out_ready) begin
                check("out_last", out_last, q.size() == 1);
                check("done", done, q.size() == 1);
                void'(q.pop_front());
            end else begin
                check("done_stall", done, 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("beats_left", q.size(), 0);
        out_ready = 1'b0;
        @(negedge clk);
        check("end_busy", busy, 0);
        check("end_valid", out_valid, 0);
        check("end_done", done, 0);
        check("end_err", err, err_exp);
        @(posedge clk); #1;
    endtask

    initial begin
        vec[0] = '{base: 5'd30, data: 32'hA3A2A1A0, err: 1'b0};
        vec[1] = '{base: 5'd2,  data: 32'h16151413, err: 1'b0};
        vec[2] = '{base: 5'd4,  data: 32'h18171615, err: 1'b0};
        vec[3] = '{base: 5'd31, data: 32'h13A3A2A1, err: 1'b0};
        vec[4] = '{base: 5'd29, data: 32'hA2A1A000, err: 1'b1};
        vec[5] = '{base: 5'd6,  data: 32'h00001817, err: 1'b1};

        rst = 1'b1; ld_valid = 0; ld_addr = 0; ld_data = 0;
        req_valid = 0; req_base = 0; req_beats = 0; out_ready = 0; err_clr = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_req_ready", req_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) do_load(i, 8'h11 + i);
        run_stream(0, 2, 0);

        do_load(30, 8'hA0); do_load(31, 8'hA1); do_load(0, 8'hA2); do_load(1, 8'hA3);
        for (int k = 0; k < 6; k++) begin
            req_valid = 1'b1; req_base = vec[k].base; req_beats = 8'd1; out_ready = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            check("vec_valid", out_valid, 1);
            check("vec_data", out_data, vec[k].data);
            check("vec_last", out_last, 1);
            check("vec_done", done, 1);
            @(posedge clk); #1;
            @(negedge clk);
            check("vec_err", err, vec[k].err);
            check("vec_busy", busy, 0);
            @(posedge clk); #1;
            err_exp = vec[k].err;
        end
        out_ready = 1'b0;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0; err_exp = 1'b0;
        @(negedge clk);
        check("err_cleared", err, 0);
        @(posedge clk); #1;

        run_stream(0, 3, 2);
        run_stream(28, 4, 2);

        // Load and request together: load wins, request goes the next cycle.
        ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 8'h55;
        req_valid = 1'b1; req_base = 5'd3; req_beats = 8'd0;
        @(negedge clk);
        check("arb_ld_ready", ld_ready, 1);
        check("arb_req_ready", req_ready, 0);
        @(posedge clk); #1;
        ld_valid = 1'b0; m_mem[3] = 8'h55; m_vld[3] = 1'b1;
        @(negedge clk);
        check("arb_req_ready2", req_ready, 1);
        check("arb_done_early", done, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("arb_done", done, 1);
        check("arb_valid", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("arb_done_once", done, 0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a stream.
        req_valid = 1'b1; req_base = 5'd0; req_beats = 8'd5; out_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        #2 rst = 1'b0;
        clear_model();
        out_ready = 1'b0;
        @(posedge clk); #1;
        run_stream(0, 1, 0);

        // Sticky err, plain clear, then clear colliding with a new error.
        repeat (2) begin
            @(negedge clk);
            check("err_sticky", err, 1);
            @(posedge clk); #1;
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("err_clr_alone", err, 0);
        @(posedge clk); #1;
        err_clr = 1'b1; req_valid = 1'b1; req_base = 5'd4; req_beats = 8'd1; out_ready = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("unl_data", out_data, 0);
        check("unl_done", done, 1);
        check("err_set_wins", err, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        err_exp = 1'b1;

        for (int it = 0; it < 40; it++) begin
            int nl = $urandom_range(1, 4);
            for (int j = 0; j < nl; j++) do_load($urandom_range(0, 31), $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1;
                @(posedge clk); #1;
                err_clr = 1'b0; err_exp = 1'b0;
            end
            run_stream($urandom_range(0, 31), $urandom_range(0, 6), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
